multi_counter: RTL
==================

Name: multi_counter

Overview:
Multi-channel programmable counter bank. It supersedes the single settable up-counter.
- NUM_CH independent counters share one clock prescaler.
- Each channel has its own enable, direction, terminal limit, terminal-action mode, synchronous load and terminal-count pulse.
- Sits beside the user-project wishbone/logic-analyzer glue as the timing source for periodic events, timeouts and one-shot delays.

Parameters:
- NUM_CH, 4, number of independent counter channels (>=1).
- WIDTH, 32, counter width per channel (>=2).
- PRESCALE_W, 8, width of shared prescaler divide value.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- prescale_i  input  PRESCALE_W  shared tick divider; tick every prescale_i+1 cycles.
- en_i  input  NUM_CH  per-channel count enable.
- dir_i  input  NUM_CH  per-channel direction; 1=up, 0=down.
- mode_i  input  2*NUM_CH  per-channel terminal action; ch k at [2k+1:2k]; 00 wrap, 01 saturate, 10 one-shot, 11 reload.
- set_i  input  NUM_CH  per-channel synchronous load strobe.
- set_value_i  input  NUM_CH*WIDTH  load/reload value; ch k at [k*WIDTH +: WIDTH].
- limit_i  input  NUM_CH*WIDTH  up-count terminal value; same packing.
- count_o  output  NUM_CH*WIDTH  registered counts; same packing.
- tc_o  output  NUM_CH  one-cycle terminal-count pulse.
- running_o  output  NUM_CH  channel armed; cleared by one-shot terminal.

Behaviour:
- Clock and reset
  - Single clock domain. Reset is synchronous and active-low (rst_n=0 sampled at posedge clk) and overrides everything.
  - Reset state: count_o=0, tc_o=0, running_o=all 1s, prescaler counter pre_r=0.
- Prescaler
  - pre_r counts every cycle, free-running; it ignores en_i.
  - tick=1 when pre_r >= prescale_i; on tick pre_r<=0, else pre_r<=pre_r+1.
  - prescale_i=0 gives tick every cycle. Lowering prescale_i below pre_r gives a tick on the next cycle, with no long stall.
- Per-channel priority, evaluated each posedge:
  1. set_i[k]=1: count<=set_value[k]; running<=1; tc<=0. The prescaler tick is ignored for this channel that cycle. The load value is not clipped to the limit.
  2. Else if tick & en_i[k] & running[k]: advance as below.
  3. Else hold count; tc<=0.
- Terminal condition (evaluated on the pre-update count)
  - Up: count >= limit. The >= makes a count loaded above the limit terminal immediately.
  - Down: count == 0.
- Advance, not terminal: up count+1, down count-1. Arithmetic never exceeds limit or underflows 0, so no modulo wrap occurs.
- Advance, terminal, by mode:
  - wrap: up->0, down->limit; tc<=1.
  - saturate: hold count (up: count<=limit if above); tc<=1 only if count was not already at terminal on the previous tick (single pulse on arrival); no repeated pulses while saturated.
  - one-shot: hold count; running<=0; tc<=1. The channel stays frozen until set_i.
  - reload: count<=set_value; tc<=1.
- Saturate arrival pulse
  - Implementation: tc fires on the advance that makes count equal terminal, not on the tick after.
  - So saturate tc coincides with the update where count first equals limit (up) or 0 (down).
  - Other modes pulse on the tick applied at terminal.
- Latency
  - count_o and tc_o are registered. They change on the edge where the tick is sampled; tc_o is high exactly one cycle per event.
- Dynamic changes
  - mode_i, dir_i and limit_i are sampled every cycle and take effect on the next tick; no shadowing.
  - Direction reversal at terminal is legal.
- limit=0, up, wrap: terminal on every tick; count stays 0 and tc pulses each tick.
- en_i low freezes count but not the prescaler phase. Re-enable resumes on the next shared tick.
- Channels are fully independent apart from the shared tick. Simultaneous set and terminal on different channels do not interact.

Test Plan:
- Reset/prescale: rst_n=0 for 2 cycles, prescale_i=3, ch0 up wrap limit=5, en=1 -> count 0,1,..,5 advancing every 4 cycles; 0 after 5 with tc_o[0] pulse for 1 cycle; running_o=1.
- Saturate down: prescale_i=0, ch1 dir=0, set_value=3 via set_i -> count 3,2,1,0,0,0; tc_o[1] exactly once (on update to 0).
- One-shot then rearm: ch2 up limit=2 one-shot -> 0,1,2; tc pulse; running_o[2]=0; count frozen at 2 for 10 cycles; set_i with value 0 -> running_o[2]=1, counting resumes.
- Reload + set priority: ch3 up limit=4 reload set_value=2 -> 2,3,4,2,3,..; assert set_i on a tick cycle with set_value=1 -> count=1, no tc.
- Edge cases: limit=0 up wrap -> tc every tick; set_value=10 with limit=4 up wrap -> next tick count=0 with tc; mid-count rst_n=0 -> all counts 0, tc 0 next cycle.
- Channel independence: all 4 channels in different modes with en toggling randomly against a reference model for 10k cycles -> zero mismatches.

Source files
------------

// File: rtl/multi_counter.sv
// Multi-channel programmable counter bank driven by one shared prescaler tick.
// Each channel has its own enable, direction, limit, terminal action, load strobe and tc pulse.
module multi_counter #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PRESCALE_W-1:0]   prescale_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       dir_i,
    input  logic [2*NUM_CH-1:0]     mode_i,
    input  logic [NUM_CH-1:0]       set_i,
    input  logic [NUM_CH*WIDTH-1:0] set_value_i,
    input  logic [NUM_CH*WIDTH-1:0] limit_i,
    output logic [NUM_CH*WIDTH-1:0] count_o,
    output logic [NUM_CH-1:0]       tc_o,
    output logic [NUM_CH-1:0]       running_o
);
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;
    localparam logic [WIDTH-1:0]      CNT_ONE = 1;

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;
    logic                  tick;

    // >= rather than == so lowering prescale_i below the current phase ticks at once
    always_comb begin
        tick  = (pre_q >= prescale_i);
        pre_d = tick ? '0 : pre_q + PRE_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [WIDTH-1:0] lim;
        logic [WIDTH-1:0] sval;
        logic [WIDTH-1:0] step_val;
        logic [1:0]       mode;
        logic             up;
        logic             term;
        logic             tc_q;
        logic             tc_d;
        logic             run_q;
        logic             run_d;

        always_comb begin
            lim      = limit_i[k*WIDTH +: WIDTH];
            sval     = set_value_i[k*WIDTH +: WIDTH];
            mode     = mode_i[2*k +: 2];
            up       = dir_i[k];
            term     = up ? (cnt_q >= lim) : (cnt_q == '0);
            step_val = up ? cnt_q + CNT_ONE : cnt_q - CNT_ONE;
            cnt_d    = cnt_q;
            tc_d     = 1'b0;
            run_d    = run_q;
            if (set_i[k]) begin
                cnt_d = sval;
                run_d = 1'b1;
            end else if (tick && en_i[k] && run_q) begin
                if (!term) begin
                    cnt_d = step_val;
                    // saturate pulses on the step that lands on the terminal value
                    if (mode == MODE_SAT) begin
                        tc_d = up ? (step_val == lim) : (step_val == '0);
                    end
                end else begin
                    case (mode)
                        MODE_WRAP: begin
                            cnt_d = up ? '0 : lim;
                            tc_d  = 1'b1;
                        end
                        MODE_SAT: begin
                            if (up && (cnt_q != lim)) begin
                                cnt_d = lim;
                                tc_d  = 1'b1;
                            end
                        end
                        MODE_ONESHOT: begin
                            run_d = 1'b0;
                            tc_d  = 1'b1;
                        end
                        default: begin
                            cnt_d = sval;
                            tc_d  = 1'b1;
                        end
                    endcase
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
                run_q <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                tc_q  <= tc_d;
                run_q <= run_d;
            end
        end

        assign count_o[k*WIDTH +: WIDTH] = cnt_q;
        assign tc_o[k]                   = tc_q;
        assign running_o[k]              = run_q;
    end

endmodule
